fifo_rd_cntrl: RTL and testbench
================================

FIFO_RD_CNTRL -- requirements
Module: fifo_rd_cntrl

Interface
REQ-001: Parameter DATA_WIDTH, default 8, width of each FIFO data word.
REQ-002: Parameter ADDR_WIDTH, default 3, memory address width; depth = 2^ADDR_WIDTH = 8 words.
REQ-003: CLK  input  1  read-domain clock; all state updates on its rising edge.
REQ-004: RST_n  input  1  asynchronous, active-low reset.
REQ-005: rinc  input  1  pop request from the consumer, sampled on the rising edge of CLK.
REQ-006: wptr_gray  input  ADDR_WIDTH+1  Gray-coded write pointer from the write domain, unsynchronized.
REQ-007: rdata_mem  input  DATA_WIDTH  combinational memory read data for the word at raddr.
REQ-008: raddr  output  ADDR_WIDTH  memory read address.
REQ-009: rptr_gray  output  ADDR_WIDTH+1  registered Gray-coded read pointer, sent to the write domain.
REQ-010: rempty  output  1  registered empty flag.
REQ-011: rdata  output  DATA_WIDTH  registered popped data word.
REQ-012: rvalid  output  1  one-cycle strobe marking rdata as newly popped.

Function
REQ-013: wptr_gray SHALL pass through a two-flop synchronizer (stage 1, stage 2, named wq2_wptr) clocked by CLK; no other logic SHALL sample wptr_gray.
REQ-014: The read side SHALL hold an ADDR_WIDTH+1-bit binary read counter rbin; raddr SHALL equal rbin[ADDR_WIDTH-1:0].
REQ-015: pop = rinc AND NOT rempty; rinc while rempty is high SHALL be ignored, with no pointer or data change and no rvalid.
REQ-016: rbin_next = rbin + pop, modulo 2^(ADDR_WIDTH+1), wrapping from 15 to 0 at default width.
REQ-017: rgray_next = (rbin_next >> 1) XOR rbin_next; rptr_gray SHALL register rgray_next each cycle.
REQ-018: rempty SHALL register (rgray_next == wq2_wptr) each cycle.
REQ-019: On a pop edge, rdata SHALL capture rdata_mem (word at the pre-increment raddr), and rvalid SHALL be 1 for the following cycle only.
REQ-020: On a non-pop edge, rdata SHALL hold its value and rvalid SHALL be 0.
REQ-021: Pop latency: rinc high in cycle N with rempty=0 -> rdata/rvalid valid in cycle N+1; raddr advances in cycle N+1.
REQ-022: Back-to-back pops SHALL sustain one word per cycle while rempty=0.
REQ-023: Reading the last word SHALL assert rempty in the very next cycle; a pop in that cycle SHALL be blocked.
REQ-024: A wptr_gray change SHALL clear rempty no later than the third CLK rising edge after the change (two sync edges plus the register edge).
REQ-025: rptr_gray SHALL change by at most one bit per cycle.
REQ-026: Full detection is owned by the write domain; this block SHALL NOT compute full.

Reset
REQ-027: RST_n low SHALL asynchronously clear rbin, rptr_gray, both synchronizer stages, rdata and rvalid to 0, and set rempty to 1.
REQ-028: Reset asserted mid-burst SHALL abort the pop in progress, with no rvalid after release.
REQ-029: Release of RST_n SHALL take effect on the next CLK rising edge, and the first pop SHALL be possible only after wq2_wptr differs from rptr_gray.

Verification
REQ-030: Reset with wptr_gray=0000 -> rempty=1, raddr=0, rptr_gray=0000, rvalid=0; rinc=1 for 5 cycles -> no change.
REQ-031: wptr_gray 0000->0001 (one word written), rdata_mem=8'hA5 -> rempty=0 by the 3rd edge; rinc=1 one cycle -> rdata=8'hA5, rvalid=1 one cycle, raddr=1, rptr_gray=0001, rempty=1.
REQ-032: Eight words written (wptr_gray=1100), continuous rinc -> eight consecutive rvalid cycles with data in addresses 0..7 order, then rempty=1, rptr_gray=1100.
REQ-033: Wrap test: 16 single-word write/read cycles -> rbin wraps 15->0, rptr_gray returns to 0000, and every rptr_gray transition flips exactly one bit.
REQ-034: RST_n pulsed low during a 4-word burst after 2 pops -> outputs match REQ-027 immediately, no rvalid follows, and raddr=0 after release.
REQ-035: wptr_gray advanced while rinc is held high at empty -> first rvalid no earlier than 3 edges after the change, and no data read from an unwritten address.

Source files
------------

// File: rtl/fifo_rd_cntrl_if.sv
// Read-side FIFO handshake bundle: consumer pop, write pointer in,
// memory read port, and the read pointer/flag/data outputs.
interface fifo_rd_cntrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  rinc;
    logic [ADDR_WIDTH:0]   wptr_gray;
    logic [DATA_WIDTH-1:0] rdata_mem;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [ADDR_WIDTH:0]   rptr_gray;
    logic                  rempty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;

    modport master (
        output rinc, wptr_gray, rdata_mem,
        input  raddr, rptr_gray, rempty, rdata, rvalid
    );

    modport slave (
        input  rinc, wptr_gray, rdata_mem,
        output raddr, rptr_gray, rempty, rdata, rvalid
    );
endinterface

// File: rtl/fifo_rd_cntrl.sv
// Async FIFO read-side controller: syncs the Gray write pointer,
// keeps the read pointer, empty flag and a registered pop data stage.
// Ports: CLK, RST_n (async active-low), bus (fifo_rd_cntrl_if.slave).
module fifo_rd_cntrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic           CLK,
    input  logic           RST_n,
    fifo_rd_cntrl_if.slave bus
);
    logic [ADDR_WIDTH:0]   wq1_wptr;
    logic [ADDR_WIDTH:0]   wq2_wptr;
    logic [ADDR_WIDTH:0]   rbin;
    logic [ADDR_WIDTH:0]   rbin_next;
    logic [ADDR_WIDTH:0]   rgray_next;
    logic [ADDR_WIDTH:0]   rgray;
    logic                  rempty_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;
    logic                  pop;

    // Only the first sync flop may touch the foreign-domain pointer.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wq1_wptr <= '0;
            wq2_wptr <= '0;
        end else begin
            wq1_wptr <= bus.wptr_gray;
            wq2_wptr <= wq1_wptr;
        end
    end

    assign pop        = bus.rinc & ~rempty_q;
    assign rbin_next  = rbin + {{ADDR_WIDTH{1'b0}}, pop};
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;

    // Empty is computed against the next pointer so the flag rises in
    // the same edge that consumes the last word.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            rbin     <= '0;
            rgray    <= '0;
            rempty_q <= 1'b1;
        end else begin
            rbin     <= rbin_next;
            rgray    <= rgray_next;
            rempty_q <= (rgray_next == wq2_wptr);
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= pop;
            if (pop) begin
                rdata_q <= bus.rdata_mem;
            end
        end
    end

    assign bus.raddr     = rbin[ADDR_WIDTH-1:0];
    assign bus.rptr_gray = rgray;
    assign bus.rempty    = rempty_q;
    assign bus.rdata     = rdata_q;
    assign bus.rvalid    = rvalid_q;
endmodule

// File: tb/tb_fifo_rd_cntrl.sv
// Directed self-checking bench for fifo_rd_cntrl.
// Drives the interface master side and models the FIFO memory.
module tb_fifo_rd_cntrl;
    logic clk;
    logic rst_n;
    logic [7:0] mem [8];
    int total;
    int bad;

    fifo_rd_cntrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

    fifo_rd_cntrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .CLK   (clk),
        .RST_n (rst_n),
        .bus   (bus.slave)
    );

    assign bus.rdata_mem = mem[bus.raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.rinc = 1'b0;
        bus.wptr_gray = 4'b0000;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        logic [3:0] prev;
        logic [3:0] cur;
        total = 0;
        bad = 0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        rst_n = 1'b1;
        bus.rinc = 1'b0;
        bus.wptr_gray = 4'b0000;
        #2;

        // reset state and ignored pops at empty
        do_reset();
        chk("rst_empty", bus.rempty, 1);
        chk("rst_raddr", bus.raddr, 0);
        chk("rst_rptr", bus.rptr_gray, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rdata", bus.rdata, 0);
        bus.rinc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("empty_pop_rvalid", bus.rvalid, 0);
        end
        chk("empty_pop_raddr", bus.raddr, 0);
        chk("empty_pop_rptr", bus.rptr_gray, 0);
        chk("empty_pop_empty", bus.rempty, 1);
        bus.rinc = 1'b0;

        // single word
        mem[0] = 8'hA5;
        bus.wptr_gray = 4'b0001;
        step();
        step();
        chk("one_empty_e2", bus.rempty, 1);
        step();
        chk("one_empty_e3", bus.rempty, 0);
        bus.rinc = 1'b1;
        step();
        bus.rinc = 1'b0;
        chk("one_rdata", bus.rdata, 8'hA5);
        chk("one_rvalid", bus.rvalid, 1);
        chk("one_raddr", bus.raddr, 1);
        chk("one_rptr", bus.rptr_gray, 4'b0001);
        chk("one_empty", bus.rempty, 1);
        step();
        chk("one_rvalid_off", bus.rvalid, 0);
        chk("one_rdata_hold", bus.rdata, 8'hA5);

        // eight-word burst
        do_reset();
        for (int i = 0; i < 8; i++) mem[i] = 8'h30 + 8'(i * 7);
        bus.wptr_gray = 4'b1100;
        step();
        step();
        step();
        chk("burst_ready", bus.rempty, 0);
        bus.rinc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("burst_rvalid", bus.rvalid, 1);
            chk("burst_rdata", bus.rdata, 8'h30 + 8'(i * 7));
        end
        chk("burst_empty", bus.rempty, 1);
        chk("burst_rptr", bus.rptr_gray, 4'b1100);
        step();
        chk("burst_blocked", bus.rvalid, 0);
        chk("burst_rptr_hold", bus.rptr_gray, 4'b1100);
        bus.rinc = 1'b0;

        // pointer wrap
        do_reset();
        prev = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            mem[i % 8] = 8'h10 + 8'(i);
            bus.wptr_gray = gray(4'(i + 1));
            step();
            step();
            step();
            bus.rinc = 1'b1;
            step();
            bus.rinc = 1'b0;
            cur = bus.rptr_gray;
            chk("wrap_rvalid", bus.rvalid, 1);
            chk("wrap_rdata", bus.rdata, 8'h10 + 8'(i));
            chk("wrap_rptr", cur, gray(4'(i + 1)));
            chk("wrap_onebit", $countones(prev ^ cur), 1);
            prev = cur;
        end
        chk("wrap_rptr_zero", bus.rptr_gray, 0);
        chk("wrap_raddr_zero", bus.raddr, 0);

        // reset mid-burst
        do_reset();
        for (int i = 0; i < 4; i++) mem[i] = 8'h50 + 8'(i);
        bus.wptr_gray = gray(4'd4);
        step();
        step();
        step();
        bus.rinc = 1'b1;
        step();
        chk("mid_pop0", bus.rdata, 8'h50);
        step();
        chk("mid_pop1", bus.rdata, 8'h51);
        rst_n = 1'b0;
        bus.wptr_gray = 4'b0000;
        #1;
        chk("mid_rst_empty", bus.rempty, 1);
        chk("mid_rst_rvalid", bus.rvalid, 0);
        chk("mid_rst_rptr", bus.rptr_gray, 0);
        chk("mid_rst_raddr", bus.raddr, 0);
        chk("mid_rst_rdata", bus.rdata, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_no_rvalid", bus.rvalid, 0);
        end
        chk("mid_raddr", bus.raddr, 0);

        // write arrives while pop is held at empty
        mem[0] = 8'hC3;
        mem[1] = 8'hEE;
        bus.wptr_gray = 4'b0001;
        step();
        chk("late_e1", bus.rvalid, 0);
        step();
        chk("late_e2", bus.rvalid, 0);
        step();
        chk("late_e3", bus.rvalid, 0);
        step();
        chk("late_e4_rvalid", bus.rvalid, 1);
        chk("late_e4_rdata", bus.rdata, 8'hC3);
        step();
        chk("late_e5_rvalid", bus.rvalid, 0);
        chk("late_e5_rdata", bus.rdata, 8'hC3);
        chk("late_e5_raddr", bus.raddr, 1);
        bus.rinc = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
